// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter that funnels pixel-solver writes onto one Avalon-MM master,
// with a full-frame fill engine that takes priority over all requesters.
module pixel_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*10-1:0] req_x,
    input  logic [NUM_REQ*9-1:0]  req_y,
    input  logic [NUM_REQ*8-1:0]  req_color,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  clear_start,
    input  logic [7:0]            clear_color,
    output logic                  clear_busy,
    output logic [ADDR_W-1:0]     m_address,
    output logic [7:0]            m_writedata,
    output logic                  m_write,
    input  logic                  m_waitrequest,
    output logic [31:0]           pixel_count
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t              state_q;
    logic                pend_q;
    logic [7:0]          pend_color_q;
    logic [PW-1:0]       ptr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          data_q;
    logic                write_q;
    logic [31:0]         count_q;

    logic                found;
    logic [PW-1:0]       gnt_idx;
    logic                grant_en;
    logic [9:0]          gx;
    logic [8:0]          gy;
    logic [7:0]          gc;
    logic                in_range;
    logic [ADDR_W-1:0]   gaddr;
    logic [PW-1:0]       ptr_d;
    logic                clear_accept;

    // Search starts at the requester after the last grant.
    always_comb begin : arb
        int idx;
        idx     = 0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

    assign grant_en  = !reset && (state_q == IDLE) && !pend_q && !clear_start && found;
    assign req_ready = grant_en ? (NUM_REQ'(1) << gnt_idx) : '0;

    assign gx       = req_x[gnt_idx*10 +: 10];
    assign gy       = req_y[gnt_idx*9 +: 9];
    assign gc       = req_color[gnt_idx*8 +: 8];
    assign in_range = ({22'd0, gx} < 32'(H_RES)) && ({23'd0, gy} < 32'(V_RES));
    assign gaddr    = ADDR_W'(gy) * ADDR_W'(H_RES) + ADDR_W'(gx);
    assign ptr_d    = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    assign clear_accept = clear_start && !pend_q && (state_q != CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            pend_color_q <= 8'd0;
            ptr_q        <= '0;
            addr_q       <= '0;
            data_q       <= 8'd0;
            write_q      <= 1'b0;
            count_q      <= 32'd0;
        end else begin
            if (clear_accept) begin
                pend_q       <= 1'b1;
                pend_color_q <= clear_color;
            end
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        state_q <= CLEAR;
                        pend_q  <= 1'b0;
                        addr_q  <= '0;
                        data_q  <= pend_color_q;
                        write_q <= 1'b1;
                    end else if (grant_en) begin
                        ptr_q <= ptr_d;
                        // Out-of-frame pixels are accepted but never reach the bus.
                        if (in_range) begin
                            state_q <= WRITE;
                            addr_q  <= gaddr;
                            data_q  <= gc;
                            write_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (!m_waitrequest) begin
                        write_q <= 1'b0;
                        count_q <= count_q + 32'd1;
                        state_q <= IDLE;
                    end
                end
                CLEAR: begin
                    if (!m_waitrequest) begin
                        if (addr_q == LAST_ADDR) begin
                            write_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy  = pend_q || (state_q == CLEAR);
    assign m_address   = addr_q;
    assign m_writedata = data_q;
    assign m_write     = write_q;
    assign pixel_count = count_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench: a 640x480 instance for arbitration/stall/drop checks and a
// 4x2 instance for frame-fill, pending-fill and reset-abort sequences.
module tb_pixel_write_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  req_valid;
    logic [39:0] req_x;
    logic [35:0] req_y;
    logic [31:0] req_color;
    logic        clear_start_b;
    logic        clear_start_s;
    logic [7:0]  clear_color;
    logic        m_waitrequest;

    logic [3:0]  req_ready,   s_req_ready;
    logic        clear_busy,  s_clear_busy;
    logic [18:0] m_address,   s_m_address;
    logic [7:0]  m_writedata, s_m_writedata;
    logic        m_write,     s_m_write;
    logic [31:0] pixel_count, s_pixel_count;

    pixel_write_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_color(req_color), .req_ready(req_ready), .clear_start(clear_start_b),
        .clear_color(clear_color), .clear_busy(clear_busy), .m_address(m_address),
        .m_writedata(m_writedata), .m_write(m_write), .m_waitrequest(m_waitrequest),
        .pixel_count(pixel_count)
    );

    pixel_write_arbiter #(.NUM_REQ(4), .H_RES(4), .V_RES(2), .ADDR_W(19)) dut_s (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_color(req_color), .req_ready(s_req_ready), .clear_start(clear_start_s),
        .clear_color(clear_color), .clear_busy(s_clear_busy), .m_address(s_m_address),
        .m_writedata(s_m_writedata), .m_write(s_m_write), .m_waitrequest(m_waitrequest),
        .pixel_count(s_pixel_count)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] valid;
        logic       wt;
        logic [3:0] rdy;
        logic       wr;
        int         addr;
        int         data;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input int x, input int y, input int c);
        req_x[i*10 +: 10]  = 10'(x);
        req_y[i*9 +: 9]    = 9'(y);
        req_color[i*8 +: 8] = 8'(c);
    endtask

    task automatic set_default();
        for (int i = 0; i < 4; i++) set_req(i, 10 + i, i + 1, 'hA0 + i);
    endtask

    task automatic add(input logic [3:0] v, input logic w, input logic [3:0] r,
                       input logic wr, input int a, input int d, input int c);
        vec_t e;
        e.valid = v; e.wt = w; e.rdy = r; e.wr = wr; e.addr = a; e.data = d; e.cnt = c;
        tbl.push_back(e);
    endtask

    task automatic run_table(input string nm);
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            req_valid     = tbl[k].valid;
            m_waitrequest = tbl[k].wt;
            #1;
            check($sformatf("%s[%0d].ready", nm, k), 32'(req_ready), 32'(tbl[k].rdy));
            check($sformatf("%s[%0d].write", nm, k), 32'(m_write), 32'(tbl[k].wr));
            if (tbl[k].wr) begin
                check($sformatf("%s[%0d].addr", nm, k), 32'(m_address), tbl[k].addr);
                check($sformatf("%s[%0d].data", nm, k), 32'(m_writedata), tbl[k].data);
            end
            check($sformatf("%s[%0d].count", nm, k), pixel_count, tbl[k].cnt);
        end
        tbl.delete();
    endtask

    initial begin
        reset = 1'b1; req_valid = 4'b1111; clear_start_b = 1'b0; clear_start_s = 1'b0;
        clear_color = 8'h00; m_waitrequest = 1'b0;
        req_x = '0; req_y = '0; req_color = '0;
        set_default();

        repeat (2) @(negedge clk);
        #1;
        check("rst.ready",   32'(req_ready), 0);
        check("rst.write",   32'(m_write), 0);
        check("rst.addr",    32'(m_address), 0);
        check("rst.data",    32'(m_writedata), 0);
        check("rst.busy",    32'(clear_busy), 0);
        check("rst.count",   pixel_count, 0);
        check("rst.s_ready", 32'(s_req_ready), 0);
        check("rst.s_busy",  32'(s_clear_busy), 0);
        req_valid = 4'b0000;
        @(negedge clk);
        reset = 1'b0;

        // all four requesters held: order 0,1,2,3,0,1,2,3
        for (int r = 0; r < 2; r++) begin
            add(4'b1111, 0, 4'b0001, 0, 0, 0, 4*r + 0);
            add(4'b1111, 0, 4'b0000, 1, 650,  'hA0, 4*r + 0);
            add(4'b1111, 0, 4'b0010, 0, 0, 0, 4*r + 1);
            add(4'b1111, 0, 4'b0000, 1, 1291, 'hA1, 4*r + 1);
            add(4'b1111, 0, 4'b0100, 0, 0, 0, 4*r + 2);
            add(4'b1111, 0, 4'b0000, 1, 1932, 'hA2, 4*r + 2);
            add(4'b1111, 0, 4'b1000, 0, 0, 0, 4*r + 3);
            add(4'b1111, 0, 4'b0000, 1, 2573, 'hA3, 4*r + 3);
        end
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 8);
        run_table("fair");

        // single write from requester 2
        set_req(2, 5, 3, 'h1C);
        @(negedge clk); req_valid = 4'b0100; m_waitrequest = 1'b0; #1;
        check("single.ready", 32'(req_ready), 32'b0100);
        check("single.idle_write", 32'(m_write), 0);
        @(negedge clk); req_valid = 4'b0000; #1;
        check("single.ready_off", 32'(req_ready), 0);
        check("single.write", 32'(m_write), 1);
        check("single.addr", 32'(m_address), 1925);
        check("single.data", 32'(m_writedata), 'h1C);
        @(negedge clk); #1;
        check("single.write_off", 32'(m_write), 0);
        check("single.count", pixel_count, 9);

        // five-cycle stall on requester 1
        add(4'b0010, 0, 4'b0010, 0, 0, 0, 9);
        for (int i = 0; i < 5; i++) add(4'b0000, 1, 4'b0000, 1, 1291, 'hA1, 9);
        add(4'b0000, 0, 4'b0000, 1, 1291, 'hA1, 9);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 10);
        run_table("stall");

        // out-of-frame drops and the last in-frame pixel
        set_req(3, 700, 0, 'h11);
        set_req(0, 0, 480, 'h22);
        set_req(1, 639, 479, 'h33);
        add(4'b1000, 0, 4'b1000, 0, 0, 0, 10);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 10);
        add(4'b0001, 0, 4'b0001, 0, 0, 0, 10);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 10);
        add(4'b0010, 0, 4'b0010, 0, 0, 0, 10);
        add(4'b0000, 0, 4'b0000, 1, 307199, 'h33, 10);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 11);
        run_table("drop");

        // 4x2 frame fill with a request held throughout
        @(negedge clk); reset = 1'b1; req_valid = 4'b0000; set_req(0, 1, 1, 'h5A);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); clear_start_s = 1'b1; clear_color = 8'h00; req_valid = 4'b0001; #1;
        check("fill.same_cycle_ready", 32'(s_req_ready), 0);
        check("fill.busy_before", 32'(s_clear_busy), 0);
        @(negedge clk); clear_start_s = 1'b0; #1;
        check("fill.busy_pending", 32'(s_clear_busy), 1);
        check("fill.ready_pending", 32'(s_req_ready), 0);
        check("fill.write_pending", 32'(s_m_write), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            clear_start_s = (k == 2);
            clear_color   = (k == 2) ? 8'h55 : 8'h00;
            m_waitrequest = (k == 3);
            #1;
            check($sformatf("fill[%0d].write", k), 32'(s_m_write), 1);
            check($sformatf("fill[%0d].addr", k), 32'(s_m_address), k);
            check($sformatf("fill[%0d].data", k), 32'(s_m_writedata), 0);
            check($sformatf("fill[%0d].ready", k), 32'(s_req_ready), 0);
            if (k == 3) begin
                @(negedge clk); m_waitrequest = 1'b0; clear_start_s = 1'b0; #1;
                check("fill.stall_addr", 32'(s_m_address), 3);
                check("fill.stall_write", 32'(s_m_write), 1);
            end
        end
        @(negedge clk); clear_start_s = 1'b0; clear_color = 8'h00; #1;
        check("fill.done_write", 32'(s_m_write), 0);
        check("fill.done_busy", 32'(s_clear_busy), 0);
        check("fill.held_grant", 32'(s_req_ready), 32'b0001);
        check("fill.count", s_pixel_count, 0);

        // fill requested while a write is stalled: the write finishes first
        @(negedge clk); req_valid = 4'b0000; clear_start_s = 1'b1; clear_color = 8'h77;
        m_waitrequest = 1'b1; #1;
        check("pend.write", 32'(s_m_write), 1);
        check("pend.addr", 32'(s_m_address), 5);
        check("pend.data", 32'(s_m_writedata), 'h5A);
        @(negedge clk); clear_start_s = 1'b0; m_waitrequest = 1'b0; #1;
        check("pend.busy", 32'(s_clear_busy), 1);
        check("pend.hold_write", 32'(s_m_write), 1);
        check("pend.hold_addr", 32'(s_m_address), 5);
        @(negedge clk); #1;
        check("pend.write_done", 32'(s_m_write), 0);
        check("pend.count", s_pixel_count, 1);
        check("pend.busy2", 32'(s_clear_busy), 1);
        @(negedge clk); #1;
        check("pend.clear_write", 32'(s_m_write), 1);
        check("pend.clear_addr", 32'(s_m_address), 0);
        check("pend.clear_data", 32'(s_m_writedata), 'h77);

        // reset in the middle of a fill
        @(negedge clk);
        @(negedge clk); reset = 1'b1; req_valid = 4'b1111; #1;
        check("abort.ready_in_reset", 32'(s_req_ready), 0);
        @(negedge clk); reset = 1'b0; #1;
        check("abort.write", 32'(s_m_write), 0);
        check("abort.busy", 32'(s_clear_busy), 0);
        check("abort.count", s_pixel_count, 0);
        check("abort.first_grant", 32'(s_req_ready), 32'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
